instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage sitting directly upstream of the instruction memory and downstream-facing toward decode. Owns the program counter, drives the word address into the combinational instruction memory, and captures each returned word with its PC into a 2-entry buffer. Decode drains the buffer through a valid/ready handshake. The stage supports branch/jump redirects that flush the buffer, and halts on a sticky fault for misaligned or out-of-range fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 256, depth of the instruction memory in 32-bit words; fetch addresses with pc[31:2] >= IMEM_WORDS fault.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; always equals the PC register.
- imem_data  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction; 32'h0 when out_valid=0.
- out_pc  out  32  PC of the head instruction; 32'h0 when out_valid=0.
- out_pc_plus4  out  32  out_pc + 4, mod 2^32; 32'h0 when out_valid=0.
- fetch_fault  out  1  sticky fault flag; fetching is halted while it is set.
- fetch_count  out  32  count of words pushed into the buffer; wraps at 2^32.

## Operation
- State: PC register, 2-entry circular buffer of {pc, instr} with 1-bit read and write pointers, 2-bit occupancy `count` (0..2), and FSM {RUN, HALT}.
- pop = out_valid & out_ready. It removes the head and advances the read pointer.
- push (RUN only, no redirect) occurs when count<2 or pop. It writes {pc, imem_data}, advances the write pointer, sets pc <= pc+4 and increments fetch_count.
- Full-and-popping: push and pop in the same cycle. Count is unchanged and throughput is 1 instruction per cycle.
- Redirect has priority over push and pop in its cycle:
  - buffer flushed (count <= 0, pointers <= 0);
  - no push;
  - pop ignored (the head is discarded even if out_ready=1);
  - pc <= {redirect_pc[31:2], 2'b00}.
- Misaligned redirect (redirect_pc[1:0] != 0): applied as above and additionally sets fetch_fault; FSM goes to HALT.
- Range check: in RUN with pc[31:2] >= IMEM_WORDS, no push occurs, fetch_fault is set and the FSM goes to HALT. The PC holds its value.
- HALT: no pushes. Buffered entries still drain via pop. Redirects still flush the buffer and load the PC but do not leave HALT. Only reset exits HALT.
- PC wraps mod 2^32 (0xFFFF_FFFC + 4 = 0). The range check normally catches this first.
- Reset, including mid-stream: pc <= RESET_PC, count/pointers <= 0, FSM <= RUN, fetch_fault <= 0, fetch_count <= 0. Reset overrides redirect, push and pop.

## Timing
- Reset values: imem_addr = RESET_PC, out_valid = 0, out_instr/out_pc/out_pc_plus4 = 0, fetch_fault = 0, fetch_count = 0.
- Fetch latency: word at PC p is pushed at the edge ending the cycle in which imem_addr = p. out_valid rises the next cycle.
- After reset deasserts: cycle 0 imem_addr = RESET_PC; cycle 1 out_valid = 1 with out_pc = RESET_PC.
- Redirect latency: redirect asserted in cycle N gives out_valid = 0 in cycle N+1 with imem_addr = target. The target instruction is valid at the output in cycle N+2.
- Stall: with out_ready = 0, the buffer fills in 2 cycles and the PC then holds. The head stays stable while out_valid=1 and out_ready=0, unless a redirect occurs.
- fetch_fault asserts the cycle after the offending edge condition and stays high until reset.

## Test plan
- Reset with RESET_PC=0, memory word i = i, out_ready=1 held -> out_valid from cycle 1; out_pc = 0,4,8,... and out_instr = 0,1,2,... every cycle; fetch_count = 3 after cycle 3.
- Hold out_ready=0 for 5 cycles, then release -> count saturates at 2; imem_addr holds at 8; the head stays pc=0 until release; the stream then resumes with no gap or duplicate.
- Redirect to 0x40 in the same cycle as a pop with a full buffer -> the next cycle out_valid=0 and imem_addr=0x40; the following cycle out_pc=0x40, out_instr=16; fetch_fault=0.
- Redirect to 0x42 -> fetch_fault=1 next cycle; imem_addr=0x40; no further pushes; fetch_count frozen.
- IMEM_WORDS=4, run from 0 with out_ready=1 -> instrs 0..3 delivered; fetch_fault rises while pc=0x10; out_valid falls after the last entry drains.
- Assert reset for 1 cycle while the buffer is full and halted -> next cycle out_valid=0, fetch_fault=0, fetch_count=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and
// queues {pc, instr} pairs in a 2-entry buffer drained by decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] entry_pc    [2];
  logic [31:0] entry_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;

  logic in_range;
  logic misaligned;
  logic take;
  logic pop;
  logic push;
  logic range_fault;
  logic fault_set;

  assign imem_addr  = pc;
  assign out_valid  = (count != 2'd0);
  assign in_range   = ({3'b000, pc[31:2]} < LIMIT);
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // A redirect discards the head even when decode is accepting it.
  assign take = out_valid & out_ready;
  assign pop  = take & ~redirect_valid;

  always_comb begin
    push        = 1'b0;
    range_fault = 1'b0;
    if (state == RUN && !redirect_valid) begin
      if (!in_range) begin
        range_fault = 1'b1;
      end else if (count != 2'd2 || take) begin
        push = 1'b1;
      end
    end
  end

  assign fault_set = (redirect_valid & misaligned) | range_fault;

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (fault_set) state_next = HALT;
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    pc_next = pc;
    unique case (1'b1)
      redirect_valid: pc_next = {redirect_pc[31:2], 2'b00};
      push:           pc_next = pc + 32'd4;
      default:        pc_next = pc;
    endcase
  end

  always_comb begin
    count_next = count;
    if (redirect_valid) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      if (redirect_valid) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (pop)  rd_ptr <= ~rd_ptr;
        if (push) wr_ptr <= ~wr_ptr;
      end
      if (fault_set) fetch_fault <= 1'b1;
      if (push)      fetch_count <= fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_pc[wr_ptr]    <= pc;
      entry_instr[wr_ptr] <= imem_data;
    end
  end

  always_comb begin
    out_instr    = 32'd0;
    out_pc       = 32'd0;
    out_pc_plus4 = 32'd0;
    if (out_valid) begin
      out_instr    = entry_instr[rd_ptr];
      out_pc       = entry_pc[rd_ptr];
      out_pc_plus4 = entry_pc[rd_ptr] + 32'd4;
    end
  end

endmodule
